// File: rtl/instr_assembler_if.sv
// Request/instruction-memory bus for instr_assembler: loader request fields
// on one side, instruction-memory write port and status on the other.
interface instr_assembler_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport master (
        output in_valid, mnem, rs, rt, rd, imm, target,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, imm, target,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );
endinterface

// File: rtl/instr_assembler.sv
// Sequential MIPS instruction encoder: captures one request per handshake,
// encodes it and writes it to instruction memory at an auto-incrementing address.
module instr_assembler #(
    parameter int unsigned ADDR_W = 5
) (
    input logic             clk,
    input logic             rst,
    input logic             clear,
    instr_assembler_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_d, err_q;
    logic              we_q, full_q, ready_q;
    logic              capture;

    logic [3:0]  mnem_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [15:0] imm_q;
    logic [25:0] target_q;

    logic [31:0] enc_word;
    logic        enc_legal;

    // Instruction encoder over the captured fields
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (mnem_q)
            4'd0:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100000};
            4'd1:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100010};
            4'd2:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100100};
            4'd3:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100101};
            4'd4:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100111};
            4'd5:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b101010};
            4'd6:    enc_word = {6'b001000, rs_q, rt_q, imm_q};
            4'd7:    enc_word = {6'b100011, rs_q, rt_q, imm_q};
            4'd8:    enc_word = {6'b101011, rs_q, rt_q, imm_q};
            4'd9:    enc_word = {6'b000100, rs_q, rt_q, imm_q};
            4'd10:   enc_word = {6'b000010, target_q};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state and datapath updates; clear overrides every other transition
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        capture = 1'b0;
        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        capture = 1'b1;
                        state_d = ENC;
                    end
                end
                ENC: begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        state_d = WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                WR: begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    state_d = (ptr_q == PTR_MAX) ? FULL : IDLE;
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered outputs track the state being entered so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            we_q    <= (state_d == WR);
            full_q  <= (state_d == FULL);
            ready_q <= (state_d == IDLE);
        end
    end

    // Request field capture; fields need only be valid at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mnem_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            target_q <= '0;
        end else if (capture) begin
            mnem_q   <= bus.mnem;
            rs_q     <= bus.rs;
            rt_q     <= bus.rt;
            rd_q     <= bus.rd;
            imm_q    <= bus.imm;
            target_q <= bus.target;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = ptr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = cnt_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
endmodule
